// File: rtl/csa_pipe_nbits_if.sv
// Handshake and operand/result bundle for csa_pipe_nbits.
// Carries the ovf result only when CSA_OVF_EN is defined.
interface csa_pipe_nbits_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic         sub;
  logic         cin;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         cout;
`ifdef CSA_OVF_EN
  logic         ovf;

  modport master (
    output in_valid, sub, cin, a, b, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, sub, cin, a, b, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
`else
  modport master (
    output in_valid, sub, cin, a, b, out_ready,
    input  in_ready, out_valid, s, cout
  );

  modport slave (
    input  in_valid, sub, cin, a, b, out_ready,
    output in_ready, out_valid, s, cout
  );
`endif
endinterface

// File: rtl/csa_pipe_nbits.sv
// Pipelined carry-select adder/subtractor, one W=M*STAGE_BLKS bit slice per stage, global stall.
// Define CSA_OVF_EN to add the two's-complement overflow output.
module csa_pipe_nbits #(
  parameter int N          = 32,
  parameter int M          = 4,
  parameter int STAGE_BLKS = 2
) (
  input logic             clk,
  input logic             rst,
  csa_pipe_nbits_if.slave bus
);
  localparam int W = M * STAGE_BLKS;
  localparam int L = (W > 0) ? N / W : 1;

  if (M < 1 || STAGE_BLKS < 1 || N < W || (W > 0 && (N % W) != 0)) begin : g_param_check
    $error("csa_pipe_nbits: N must be a positive multiple of M*STAGE_BLKS");
  end

  logic en;

  // Per-stage inputs (from the previous stage register) and next-state values.
  logic         v_in [L];
  logic         c_in [L];
  logic [N-1:0] a_in [L];
  logic [N-1:0] b_in [L];
  logic [N-1:0] s_in [L];
  logic [N-1:0] s_nx [L];
  logic         c_nx [L];

  // Stage registers.
  logic         v_q [L];
  logic         c_q [L];
  logic [N-1:0] a_q [L];
  logic [N-1:0] b_q [L];
  logic [N-1:0] s_q [L];

  // One stall signal freezes every stage, so results never reorder or drop.
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  for (genvar j = 0; j < L; j++) begin : g_stage
    localparam int LO = j * W;

    if (j == 0) begin : g_first
      always_comb begin
        v_in[j] = bus.in_valid;
        a_in[j] = bus.a;
        b_in[j] = bus.sub ? ~bus.b : bus.b;
        c_in[j] = bus.sub | bus.cin;
        s_in[j] = '0;
      end
    end else begin : g_next
      always_comb begin
        v_in[j] = v_q[j-1];
        a_in[j] = a_q[j-1];
        b_in[j] = b_q[j-1];
        c_in[j] = c_q[j-1];
        s_in[j] = s_q[j-1];
      end
    end

    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    always_comb begin
      logic         c;
      logic [M:0]   r0;
      logic [M:0]   r1;
      int           lo;
      s_nx[j] = s_in[j];
      c       = c_in[j];
      r0      = '0;
      r1      = '0;
      lo      = LO;
      for (int k = 0; k < STAGE_BLKS; k++) begin
        lo = LO + k * M;
        if (j == 0 && k == 0) begin
          // The least significant block ripples; it sees the carry-in directly.
          for (int i = 0; i < M; i++) begin
            s_nx[j][lo+i] = a_in[j][lo+i] ^ b_in[j][lo+i] ^ c;
            c = (a_in[j][lo+i] & b_in[j][lo+i]) | (c & (a_in[j][lo+i] ^ b_in[j][lo+i]));
          end
        end else begin
          r0 = {1'b0, a_in[j][lo +: M]} + {1'b0, b_in[j][lo +: M]};
          r1 = {1'b0, a_in[j][lo +: M]} + {1'b0, b_in[j][lo +: M]} + (M+1)'(1);
          s_nx[j][lo +: M] = c ? r1[M-1:0] : r0[M-1:0];
          c = r0[M] | (r1[M] & c);
        end
      end
      c_nx[j] = c;
    end

    // NOTE: state updates use non-blocking assignment so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q[j] <= 1'b0;
        c_q[j] <= 1'b0;
        s_q[j] <= '0;
      end else if (en) begin
        v_q[j] <= v_in[j];
        c_q[j] <= c_nx[j];
        s_q[j] <= s_nx[j];
      end
    end

    if (j < L - 1) begin : g_operands
      // NOTE: operand registers are left unreset; the valid bits alone decide whether data matters.
      always_ff @(posedge clk) begin
        if (en) begin
          a_q[j] <= a_in[j];
          b_q[j] <= b_in[j];
        end
      end
    end
  end

  assign bus.out_valid = v_q[L-1];
  assign bus.s         = s_q[L-1];
  assign bus.cout      = c_q[L-1];

`ifdef CSA_OVF_EN
  logic ovf_q;

  // Sign bits ride along with the operands, so overflow resolves in the final stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= (a_in[L-1][N-1] == b_in[L-1][N-1]) && (s_nx[L-1][N-1] != a_in[L-1][N-1]);
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_csa_pipe_nbits.sv
// Self-checking bench for csa_pipe_nbits: arithmetic reference model with in-order scoreboard
// plus directed vectors with literal expectations.
module tb_csa_pipe_nbits;
  localparam int N  = 32;
  localparam int M  = 4;
  localparam int SB = 2;
  localparam int L  = N / (M * SB);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csa_pipe_nbits_if #(.N(N)) bus ();

  csa_pipe_nbits #(.N(N), .M(M), .STAGE_BLKS(SB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;
  } result_t;

  result_t exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic result_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                    input logic sub, input logic cin);
    result_t      r;
    logic [N:0]   full;
    logic [N-1:0] b_eff;
    b_eff  = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, b_eff} + ((sub || cin) ? (N+1)'(1) : (N+1)'(0));
    r.s    = full[N-1:0];
    r.cout = full[N];
    r.ovf  = (a[N-1] == b_eff[N-1]) && (full[N-1] != a[N-1]);
    return r;
  endfunction

  function automatic logic dut_ovf();
`ifdef CSA_OVF_EN
    return bus.ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard: push on accept, pop and compare on result transfer, verify hold during stall.
  logic    held_v = 1'b0;
  result_t held;
  always @(negedge clk) begin
    result_t r;
    if (rst !== 1'b0) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("stall_hold_valid", bus.out_valid, 1);
        check("stall_hold_s", bus.s, held.s);
        check("stall_hold_cout", bus.cout, held.cout);
        check("stall_hold_ovf", dut_ovf(), held.ovf);
      end
      held_v = 1'b0;
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", bus.out_valid, 0);
        end else if (bus.out_ready === 1'b1) begin
          r = exp_q.pop_front();
          check("model_s", bus.s, r.s);
          check("model_cout", bus.cout, r.cout);
`ifdef CSA_OVF_EN
          check("model_ovf", bus.ovf, r.ovf);
`endif
        end else begin
          held_v = 1'b1;
          held   = '{s: bus.s, cout: bus.cout, ovf: dut_ovf()};
        end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
        exp_q.push_back(model(bus.a, bus.b, bus.sub, bus.cin));
    end
  end

  // Single transaction into an idle pipeline; called #1 after a rising edge.
  task automatic run_one(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                         input logic cin, output result_t got, output int lat);
    bus.a = a; bus.b = b; bus.sub = sub; bus.cin = cin; bus.in_valid = 1'b1;
    @(negedge clk);
    check("accept_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    got = '{s: bus.s, cout: bus.cout, ovf: dut_ovf()};
  endtask

  initial begin
    result_t got;
    int      lat;
    int      nvalid, first, last, idx, nstale;
    logic    acc;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_s", bus.s, 0);
    check("reset_cout", bus.cout, 0);
    check("reset_ovf", dut_ovf(), 0);
    check("reset_in_ready", bus.in_ready, 1);

    // Directed vectors with literal results.
    run_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, got, lat);
    check("ripple_s", got.s, 32'h0000_0000);
    check("ripple_cout", got.cout, 1);
    check("ripple_latency", lat, L - 1);
    run_one(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, got, lat);
    check("sub_borrow_s", got.s, 32'hFFFF_FFFE);
    check("sub_borrow_cout", got.cout, 0);
    run_one(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, got, lat);
    check("sub_noborrow_s", got.s, 32'h0000_0002);
    check("sub_noborrow_cout", got.cout, 1);
    run_one(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, got, lat);
    check("add_cin_s", got.s, 32'h2345_678A);
    check("add_cin_cout", got.cout, 0);
`ifdef CSA_OVF_EN
    run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, got, lat);
    check("ovf_pos_s", got.s, 32'h8000_0000);
    check("ovf_pos", got.ovf, 1);
    run_one(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, got, lat);
    check("ovf_neg_s", got.s, 32'h7FFF_FFFF);
    check("ovf_neg", got.ovf, 1);
    run_one(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, got, lat);
    check("ovf_none", got.ovf, 0);
`endif
    repeat (L + 2) @(posedge clk);
    #1;

    // Back-to-back burst of 100 random operations.
    nvalid = 0; first = -1; last = -1;
    for (int i = 0; i < 100 + L + 3; i++) begin
      if (i < 100) begin
        bus.in_valid = 1'b1;
        bus.a   = $urandom;
        bus.b   = $urandom;
        bus.sub = 1'($urandom_range(0, 1));
        bus.cin = 1'($urandom_range(0, 1));
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        nvalid++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check("burst_count", nvalid, 100);
    check("burst_contiguous", last - first + 1, 100);

    // Backpressure: stall 5 cycles with the pipeline full, source holds operands.
    idx = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.out_ready = !(cyc >= 8 && cyc < 13);
      if (idx < 20) begin
        bus.in_valid = 1'b1;
        bus.a   = 32'hF000_0000 + 32'(idx * 32'h0111_1111);
        bus.b   = 32'h0123_4567 ^ 32'(idx);
        bus.sub = idx[0];
        bus.cin = idx[1];
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.out_ready === 1'b0 && bus.out_valid === 1'b1)
        check("stall_in_ready", bus.in_ready, 0);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    bus.out_ready = 1'b1;
    check("bp_all_accepted", idx, 20);
    check("bp_drained", exp_q.size(), 0);

    // Reset with three items in flight.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 32'(i + 1); bus.b = 32'h10; bus.sub = 1'b0; bus.cin = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_s", bus.s, 0);
    check("midrst_cout", bus.cout, 0);
    nstale = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) nstale++;
    end
    check("midrst_no_stale", nstale, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
